// File: rtl/prbs7_ber_checker.sv
// rtl/prbs7_ber_checker.sv - PRBS7 (x^7+x^6+1, XNOR) self-synchronous checker with BER counters
// Optional loss-of-lock window compiled in with `define PRBS_CHK_LOL_EN.
module prbs7_ber_checker #(
  parameter int CNT_W       = 32,
  parameter int LOCK_BITS   = 16,
  parameter int LOSS_WINDOW = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             locked,
  output logic             error_pulse,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic             saturated
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam int MW = $clog2(LOCK_BITS + 1);

  state_t          state_q, state_d;
  logic [6:0]      r;
  logic [2:0]      fill_q, fill_d;
  logic [MW-1:0]   match_q, match_d;
  logic            mismatch;
  logic            count_en;
  logic [CNT_W-1:0] bit_count_inc;

`ifdef PRBS_CHK_LOL_EN
  localparam int WW = $clog2(LOSS_WINDOW + 1);
  localparam int TW = $clog2(LOSS_THRESH + 1);
  logic [WW-1:0] win_bits_q, win_bits_d;
  logic [TW-1:0] win_errs_q, win_errs_d;
`endif

  assign mismatch      = bit_valid & (bit_in != ~(r[6] ^ r[5]));
  // Counters freeze at all-ones so the error ratio stays meaningful.
  assign count_en      = bit_valid && (state_q == LOCKED) && !(&bit_count);
  assign bit_count_inc = bit_count + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    match_d = match_q;
`ifdef PRBS_CHK_LOL_EN
    win_bits_d = win_bits_q;
    win_errs_d = win_errs_q;
`endif
    if (bit_valid) begin
      case (state_q)
        HUNT: begin
          if (fill_q == 3'd6) begin
            state_d = VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end
        VERIFY: begin
          if (mismatch) begin
            match_d = '0;
          end else if (match_q == MW'(LOCK_BITS - 1)) begin
            state_d = LOCKED;
            match_d = '0;
          end else begin
            match_d = match_q + MW'(1);
          end
        end
        LOCKED: begin
`ifdef PRBS_CHK_LOL_EN
          if (mismatch && (win_errs_q == TW'(LOSS_THRESH - 1))) begin
            state_d    = HUNT;
            win_bits_d = '0;
            win_errs_d = '0;
          end else if (win_bits_q == WW'(LOSS_WINDOW - 1)) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            win_bits_d = win_bits_q + WW'(1);
            win_errs_d = win_errs_q + TW'(mismatch);
          end
`endif
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      r           <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      locked      <= 1'b0;
      error_pulse <= 1'b0;
      bit_count   <= '0;
      err_count   <= '0;
      saturated   <= 1'b0;
`ifdef PRBS_CHK_LOL_EN
      win_bits_q  <= '0;
      win_errs_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      locked      <= (state_d == LOCKED);
      error_pulse <= 1'b0;
`ifdef PRBS_CHK_LOL_EN
      win_bits_q  <= win_bits_d;
      win_errs_q  <= win_errs_d;
`endif
      if (bit_valid) begin
        r <= {r[5:0], bit_in};
      end
      // A clear coinciding with a bit discards that bit from the counts.
      if (clear) begin
        bit_count <= '0;
        err_count <= '0;
        saturated <= 1'b0;
      end else if (count_en) begin
        bit_count <= bit_count_inc;
        saturated <= &bit_count_inc;
        if (mismatch) begin
          err_count   <= err_count + CNT_W'(1);
          error_pulse <= 1'b1;
        end
      end
    end
  end

endmodule
